mem_responder: RTL and testbench

//   Multi-channel memory responder: the far end of the controller's mem_* channel interface.

---
 rtl/gpu_mem_pkg.sv | 17 +
 rtl/mem_resp_channel.sv | 137 +++++++++++++
 rtl/mem_responder.sv | 96 +++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// ----------------------------------------------------------------------------
// gpu_mem_pkg
//   Shared types for the memory responder: the per-channel request FSM
//   encoding and the base latency-counter width.
// ----------------------------------------------------------------------------
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        RESP_IDLE,
        RESP_BUSY,
        RESP_ACK,
        RESP_DRAIN
    } resp_state_t;

    localparam int unsigned RESP_CNT_BITS = 4;

endpackage

// File: rtl/mem_resp_channel.sv
// ----------------------------------------------------------------------------
// mem_resp_channel
//   One request channel of the memory responder. Accepts a single read or
//   write request in IDLE, captures address/data, counts out the access
//   latency and raises a one-cycle commit strobe on the last BUSY cycle so the
//   top level can touch the array on the edge that raises ready.
//   Optional macro MEM_RESP_RAND_LAT_EN adds an 8-bit LFSR that stretches
//   each request's latency by 0..3 cycles.
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   rd_valid_i/addr_i    read request and address
//   wr_valid_i/addr_i    write request, address
//   wr_data_i            write data
//   commit_o             last BUSY cycle: array access happens at next edge
//   op_write_o           captured operation (1 = write)
//   addr_o, data_o       captured address and write data
//   ready_o              one-cycle completion pulse (ACK state)
// ----------------------------------------------------------------------------
module mem_resp_channel
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned LATENCY      = 2,
    parameter bit          WRITE_ENABLE = 1'b1
`ifdef MEM_RESP_RAND_LAT_EN
    ,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_valid_i,
    input  logic [ADDR_BITS-1:0] rd_addr_i,
    input  logic                 wr_valid_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    output logic                 commit_o,
    output logic                 op_write_o,
    output logic [ADDR_BITS-1:0] addr_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 ready_o
);

`ifdef MEM_RESP_RAND_LAT_EN
    // One extra bit so LATENCY-1+3 never wraps.
    localparam int unsigned CNT_W = RESP_CNT_BITS + 1;
`else
    localparam int unsigned CNT_W = RESP_CNT_BITS;
`endif

    resp_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   op_q, op_d;
    logic                   wr_req;
    logic [CNT_W-1:0]       lat_load;

    assign wr_req = WRITE_ENABLE && wr_valid_i;

`ifdef MEM_RESP_RAND_LAT_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form
    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign lat_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
    assign lat_load = CNT_W'(LATENCY - 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
`ifdef MEM_RESP_RAND_LAT_EN
        lfsr_d  = lfsr_q;
`endif
        case (state_q)
            RESP_IDLE: begin
                // Read has priority when both valids are high.
                if (rd_valid_i || wr_req) begin
                    state_d = RESP_BUSY;
                    cnt_d   = lat_load;
                    op_d    = !rd_valid_i;
                    addr_d  = rd_valid_i ? rd_addr_i : wr_addr_i;
                    if (!rd_valid_i) data_d = wr_data_i;
`ifdef MEM_RESP_RAND_LAT_EN
                    lfsr_d  = {lfsr_q[6:0], lfsr_fb};
`endif
                end
            end
            RESP_BUSY: begin
                if (cnt_q == '0) state_d = RESP_ACK;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RESP_ACK:   state_d = RESP_DRAIN;
            RESP_DRAIN: begin
                // Wait for the served valid to fall so a held request never reissues.
                if (!(op_q ? wr_req : rd_valid_i)) state_d = RESP_IDLE;
            end
            default:    state_d = RESP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESP_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= 1'b0;
`ifdef MEM_RESP_RAND_LAT_EN
            lfsr_q  <= LFSR_SEED;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
`ifdef MEM_RESP_RAND_LAT_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign commit_o   = (state_q == RESP_BUSY) && (cnt_q == '0);
    assign ready_o    = (state_q == RESP_ACK);
    assign op_write_o = op_q;
    assign addr_o     = addr_q;
    assign data_o     = data_q;

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//   Multi-channel on-chip memory model at the far end of the controller's
//   mem_* interface. Each channel serves one request at a fixed latency; the
//   top holds the storage array, commits writes in channel order and samples
//   read data. Optional macro MEM_RESP_RAND_LAT_EN enables per-channel random
//   latency stretch (LATENCY..LATENCY+3).
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   mem_read_*           per-channel read request / address / ready / data
//   mem_write_*          per-channel write request / address / data / ready
//   dbg_addr, dbg_data   backdoor: combinational mem[dbg_addr]
// ----------------------------------------------------------------------------
module mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned LATENCY      = 2,
    parameter bit          WRITE_ENABLE = 1'b1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    output logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_ready,
    input  logic [ADDR_BITS-1:0]                     dbg_addr,
    output logic [DATA_BITS-1:0]                     dbg_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [NUM_CHANNELS-1:0]                commit, op_wr, chan_ready;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] chan_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] chan_data;

    logic [DATA_BITS-1:0]                   mem_q [DEPTH];
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data_q;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        mem_resp_channel #(
            .ADDR_BITS   (ADDR_BITS),
            .DATA_BITS   (DATA_BITS),
            .LATENCY     (LATENCY),
            .WRITE_ENABLE(WRITE_ENABLE)
`ifdef MEM_RESP_RAND_LAT_EN
            ,
            .LFSR_SEED   (8'(8'hA5 + c))
`endif
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .rd_valid_i(mem_read_valid[c]),
            .rd_addr_i (mem_read_address[c]),
            .wr_valid_i(mem_write_valid[c]),
            .wr_addr_i (mem_write_address[c]),
            .wr_data_i (mem_write_data[c]),
            .commit_o  (commit[c]),
            .op_write_o(op_wr[c]),
            .addr_o    (chan_addr[c]),
            .data_o    (chan_data[c]),
            .ready_o   (chan_ready[c])
        );
    end

    // Reads sample the pre-edge array (read-before-write on conflicts);
    // writes are scheduled in ascending channel order so the last
    // non-blocking update, the highest index, wins on a shared address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            read_data_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (commit[c] && !op_wr[c]) read_data_q[c] <= mem_q[chan_addr[c]];
            end
            if (WRITE_ENABLE) begin
                for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                    if (commit[c] && op_wr[c]) mem_q[chan_addr[c]] <= chan_data[c];
                end
            end
        end
    end

    assign mem_read_ready  = chan_ready & ~op_wr;
    assign mem_write_ready = WRITE_ENABLE ? (chan_ready & op_wr) : '0;
    assign mem_read_data   = read_data_q;
    assign dbg_data        = mem_q[dbg_addr];

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [3:0]      rv, rr, wv, wrr;
    logic [3:0][7:0] ra, rd, wa, wd;
    logic [7:0]      dbg_addr, dbg_data;

    logic [3:0]      rv2, rr2, wv2, wrr2;
    logic [3:0][7:0] ra2, rd2, wa2, wd2;
    logic [7:0]      dbg_addr2, dbg_data2;

    int tests = 0;
    int fails = 0;

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(2), .WRITE_ENABLE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr), .mem_read_data(rd),
        .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wrr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(2), .WRITE_ENABLE(1'b0)) dut_ro (
        .clk(clk), .reset(reset),
        .mem_read_valid(rv2), .mem_read_address(ra2), .mem_read_ready(rr2), .mem_read_data(rd2),
        .mem_write_valid(wv2), .mem_write_address(wa2), .mem_write_data(wd2), .mem_write_ready(wrr2),
        .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on dut, return cycles from sampling edge to ready (-1 on timeout).
    task automatic do_req(input int ch, input bit is_wr, input logic [7:0] addr,
                          input logic [7:0] data, output int lat, output logic [7:0] rdata);
        lat = -1;
        rdata = '0;
        if (is_wr) begin wa[ch] = addr; wd[ch] = data; wv[ch] = 1'b1; end
        else       begin ra[ch] = addr; rv[ch] = 1'b1; end
        for (int k = 0; k < 30 && lat < 0; k++) begin
            tick();
            if (is_wr ? wrr[ch] : rr[ch]) begin lat = k; rdata = rd[ch]; end
        end
        wv[ch] = 1'b0;
        rv[ch] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rv = '0; ra = '0; wv = '0; wa = '0; wd = '0; dbg_addr = 8'h10;
        rv2 = '0; ra2 = '0; wv2 = '0; wa2 = '0; wd2 = '0; dbg_addr2 = 8'h00;
        repeat (2) tick();
        tests++; if ({rr, wrr, rr2, wrr2} !== 16'h0) begin fails++; $display("FAIL reset_ready: got %h expected 0000", {rr, wrr, rr2, wrr2}); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 00000000", rd); end
        tests++; if (dbg_data !== 8'h00) begin fails++; $display("FAIL reset_mem: got %h expected 00", dbg_data); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        int lat;
        logic [7:0] d;
        logic exp;
        do_req(0, 1'b1, 8'h10, 8'h3C, lat, d);
        tests++; if (lat !== 2) begin fails++; $display("FAIL lat_write: got %0d expected 2", lat); end
        dbg_addr = 8'h10; #1;
        tests++; if (dbg_data !== 8'h3C) begin fails++; $display("FAIL lat_preload: got %h expected 3c", dbg_data); end
        ra[0] = 8'h10; rv[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) ra[0] = 8'hFF;
            exp = (k == 2);
            tests++; if (rr[0] !== exp) begin fails++; $display("FAIL lat_ready k=%0d: got %b expected %b", k, rr[0], exp); end
            if (k >= 2) begin
                tests++; if (rd[0] !== 8'h3C) begin fails++; $display("FAIL lat_data k=%0d: got %h expected 3c", k, rd[0]); end
            end
        end
        rv[0] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_write_read();
        int lat;
        logic [7:0] d;
        logic exp;
        wa[1] = 8'h20; wd[1] = 8'h5A; wv[1] = 1'b1; dbg_addr = 8'h20;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) wd[1] = 8'h00;
            exp = (k == 2);
            tests++; if (wrr[1] !== exp) begin fails++; $display("FAIL wr_ready k=%0d: got %b expected %b", k, wrr[1], exp); end
            if (k == 1) begin
                tests++; if (dbg_data !== 8'h00) begin fails++; $display("FAIL wr_early: got %h expected 00", dbg_data); end
            end
            if (k == 2) begin
                tests++; if (dbg_data !== 8'h5A) begin fails++; $display("FAIL wr_commit: got %h expected 5a", dbg_data); end
            end
        end
        wv[1] = 1'b0;
        repeat (2) tick();
        do_req(1, 1'b0, 8'h20, 8'h00, lat, d);
        tests++; if (lat !== 2) begin fails++; $display("FAIL wr_rd_lat: got %0d expected 2", lat); end
        tests++; if (d !== 8'h5A) begin fails++; $display("FAIL wr_rd_data: got %h expected 5a", d); end
    endtask

    task automatic test_held_valid();
        int lat;
        int pulses;
        int first;
        logic [7:0] d;
        pulses = 0; first = -1;
        ra[2] = 8'h20; rv[2] = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            if (rr[2]) begin pulses++; if (first < 0) first = k; end
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL held_pulses: got %0d expected 1", pulses); end
        tests++; if (first !== 2) begin fails++; $display("FAIL held_first: got %0d expected 2", first); end
        tests++; if (rd[2] !== 8'h5A) begin fails++; $display("FAIL held_data: got %h expected 5a", rd[2]); end
        rv[2] = 1'b0;
        repeat (2) tick();
        do_req(2, 1'b0, 8'h10, 8'h00, lat, d);
        tests++; if (lat !== 2 || d !== 8'h3C) begin fails++; $display("FAIL held_reissue: got lat %0d data %h expected lat 2 data 3c", lat, d); end
    endtask

    task automatic test_read_priority();
        int rp;
        int wp;
        rp = 0; wp = 0;
        ra[2] = 8'h10; rv[2] = 1'b1;
        wa[2] = 8'h10; wd[2] = 8'hEE; wv[2] = 1'b1;
        dbg_addr = 8'h10;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rr[2]) rp++;
            if (wrr[2]) wp++;
        end
        tests++; if (rp !== 1 || wp !== 0) begin fails++; $display("FAIL prio_pulses: got rd %0d wr %0d expected rd 1 wr 0", rp, wp); end
        tests++; if (dbg_data !== 8'h3C || rd[2] !== 8'h3C) begin fails++; $display("FAIL prio_data: got mem %h rdata %h expected 3c 3c", dbg_data, rd[2]); end
        rv[2] = 1'b0; wv[2] = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_conflict();
        int lat;
        logic [7:0] d;
        do_req(0, 1'b1, 8'h40, 8'h77, lat, d);
        tests++; if (lat !== 2) begin fails++; $display("FAIL cf_preload: got %0d expected 2", lat); end
        wa[0] = 8'h40; wd[0] = 8'h11; wv[0] = 1'b1;
        wa[3] = 8'h40; wd[3] = 8'h33; wv[3] = 1'b1;
        ra[1] = 8'h40; rv[1] = 1'b1;
        dbg_addr = 8'h40;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 2) begin
                tests++; if ({wrr[0], wrr[3], rr[1]} !== 3'b111) begin fails++; $display("FAIL cf_ready: got %b expected 111", {wrr[0], wrr[3], rr[1]}); end
                tests++; if (dbg_data !== 8'h33) begin fails++; $display("FAIL cf_winner: got %h expected 33", dbg_data); end
                tests++; if (rd[1] !== 8'h77) begin fails++; $display("FAIL cf_old_read: got %h expected 77", rd[1]); end
            end
        end
        wv = '0; rv = '0;
        repeat (2) tick();
        do_req(2, 1'b0, 8'h40, 8'h00, lat, d);
        tests++; if (d !== 8'h33) begin fails++; $display("FAIL cf_readback: got %h expected 33", d); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [7:0] d;
        seen = 0;
        ra[0] = 8'h20; rv[0] = 1'b1; dbg_addr = 8'h20;
        tick();
        reset = 1'b0;
        #1;
        tests++; if ({rr, wrr} !== 8'h00) begin fails++; $display("FAIL rm_ready: got %h expected 00", {rr, wrr}); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL rm_rdata: got %h expected 00000000", rd); end
        tests++; if (dbg_data !== 8'h00) begin fails++; $display("FAIL rm_mem: got %h expected 00", dbg_data); end
        rv[0] = 1'b0;
        repeat (2) begin tick(); if (rr !== 4'h0) seen++; end
        reset = 1'b1;
        repeat (3) begin tick(); if (rr !== 4'h0) seen++; end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rm_no_ready: got %0d expected 0", seen); end
        do_req(0, 1'b1, 8'h20, 8'hC3, lat, d);
        tests++; if (lat !== 2) begin fails++; $display("FAIL rm_wr_lat: got %0d expected 2", lat); end
        do_req(0, 1'b0, 8'h20, 8'h00, lat, d);
        tests++; if (lat !== 2 || d !== 8'hC3) begin fails++; $display("FAIL rm_rd: got lat %0d data %h expected lat 2 data c3", lat, d); end
    endtask

    task automatic test_no_write();
        int cnt;
        int lat;
        cnt = 0; lat = -1;
        wa2 = {8'h04, 8'h03, 8'h02, 8'h01};
        wd2 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        wv2 = 4'hF;
        dbg_addr2 = 8'h01;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (wrr2 !== 4'h0) cnt++;
        end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL ro_wready: got %0d pulses expected 0", cnt); end
        tests++; if (dbg_data2 !== 8'h00) begin fails++; $display("FAIL ro_mem: got %h expected 00", dbg_data2); end
        ra2[0] = 8'h01; rv2[0] = 1'b1;
        for (int k = 0; k < 30 && lat < 0; k++) begin
            tick();
            if (rr2[0]) lat = k;
        end
        tests++; if (lat !== 2) begin fails++; $display("FAIL ro_read_lat: got %0d expected 2", lat); end
        tests++; if (rd2[0] !== 8'h00) begin fails++; $display("FAIL ro_read_data: got %h expected 00", rd2[0]); end
        rv2 = '0; wv2 = '0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_write_read();
        test_held_valid();
        test_read_priority();
        test_conflict();
        test_reset_mid();
        test_no_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
